// File: rtl/adder_seq_ctrl_if.sv
// Handshake and adder-facing bundle for adder_seq_ctrl.
// slave is the sequencer side; master is the host plus adder-under-test side.
interface adder_seq_ctrl_if #(
    parameter int N  = 4,
    parameter int AW = 7
);
    logic          start;
    logic          vec_we;
    logic [AW-1:0] vec_waddr;
    logic [N:0]    vec_wdata;
    logic [N-1:0]  a;
    logic [N-1:0]  b;
    logic          cin;
    logic [N-1:0]  sum;
    logic          cout;
    logic          busy;
    logic          done;
    logic          mismatch;
    logic [15:0]   vec_cnt;
    logic [15:0]   err_cnt;

    modport master (
        output start, vec_we, vec_waddr, vec_wdata, sum, cout,
        input  a, b, cin, busy, done, mismatch, vec_cnt, err_cnt
    );

    modport slave (
        input  start, vec_we, vec_waddr, vec_wdata, sum, cout,
        output a, b, cin, busy, done, mismatch, vec_cnt, err_cnt
    );
endinterface

// File: rtl/adder_seq_ctrl.sv
// Replays a/b/cin vectors from memory into an adder and checks {cout,sum}; LAT+4 cycles per vector.
// start is taken only in IDLE/DONE (ignored while busy); ADDER_SEQ_STOP_ON_ERR_EN ends a run at the first failure.
module adder_seq_ctrl #(
    parameter int N     = 4,
    parameter int DEPTH = 99,
    parameter int LAT   = 1,
    parameter int AW    = $clog2(DEPTH)
) (
    input logic             clk,
    input logic             rst_n,
    adder_seq_ctrl_if.slave bus
);
    localparam int NVEC = DEPTH / 3;
    localparam int PW   = AW + 2;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
    localparam logic [AW:0]   DEPTH_W = (AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        IDLE, FETCH_A, FETCH_B, FETCH_C, SETTLE, CHECK, DONE
    } state_t;

    state_t        state;
    logic [N-1:0]  mem [DEPTH];
    logic [PW-1:0] ptr;
    logic [N-1:0]  sh_a, sh_b, a_q, b_q, rd_word;
    logic          cin_q, busy_q, done_q, mismatch_q;
    logic [15:0]   vec_cnt_q, err_cnt_q;
    logic [7:0]    settle;
    logic [N:0]    golden;
    logic          fail, last_vec, stop, wr_ok, unused_wbit;

    assign rd_word     = mem[ptr[AW-1:0]];
    assign unused_wbit = bus.vec_wdata[N];
    assign golden      = {1'b0, a_q} + {1'b0, b_q} + {{N{1'b0}}, cin_q};
    assign fail        = golden != {bus.cout, bus.sum};
    // ptr already points past the vector under check
    assign last_vec    = (ptr + PW'(3)) > DEPTH_P;
`ifdef ADDER_SEQ_STOP_ON_ERR_EN
    assign stop        = last_vec | fail;
`else
    assign stop        = last_vec;
`endif

    assign wr_ok = bus.vec_we && (state == IDLE || state == DONE) &&
                   ({1'b0, bus.vec_waddr} < DEPTH_W);

    always_ff @(posedge clk) begin
        if (wr_ok) mem[bus.vec_waddr] <= bus.vec_wdata[N-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= '0;
            sh_a       <= '0;
            sh_b       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            cin_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mismatch_q <= 1'b0;
            vec_cnt_q  <= '0;
            err_cnt_q  <= '0;
            settle     <= '0;
        end else begin
            mismatch_q <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        vec_cnt_q <= '0;
                        err_cnt_q <= '0;
                        ptr       <= '0;
                        if (NVEC == 0) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            state  <= FETCH_A;
                            done_q <= 1'b0;
                            busy_q <= 1'b1;
                        end
                    end
                end
                FETCH_A: begin
                    sh_a  <= rd_word;
                    ptr   <= ptr + 1'b1;
                    state <= FETCH_B;
                end
                FETCH_B: begin
                    sh_b  <= rd_word;
                    ptr   <= ptr + 1'b1;
                    state <= FETCH_C;
                end
                FETCH_C: begin
                    a_q    <= sh_a;
                    b_q    <= sh_b;
                    cin_q  <= rd_word[0];
                    ptr    <= ptr + 1'b1;
                    settle <= 8'(LAT);
                    state  <= SETTLE;
                end
                SETTLE: begin
                    if (settle <= 8'd1) state <= CHECK;
                    else settle <= settle - 1'b1;
                end
                CHECK: begin
                    vec_cnt_q <= vec_cnt_q + 1'b1;
                    if (fail) begin
                        mismatch_q <= 1'b1;
                        if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 1'b1;
                    end
                    if (stop) begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        state <= FETCH_A;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.a        = a_q;
    assign bus.b        = b_q;
    assign bus.cin      = cin_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.mismatch = mismatch_q;
    assign bus.vec_cnt  = vec_cnt_q;
    assign bus.err_cnt  = err_cnt_q;
endmodule
